// File: rtl/mmio_pkg.sv
// mmio_pkg: shared encodings for the memory-mapped IO initiator.
//   - cpu_size encodings (byte / half / word)
//   - initiator state enum
//   - register offsets inside the IO window
package mmio_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [2:0] OFF_OUT = 3'd0;
  localparam logic [2:0] OFF_IN  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RCAP = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } mmio_state_e;

endpackage

// File: rtl/mmio_lane.sv
// mmio_lane: combinational byte-lane logic for the IO initiator.
//   size        : access size (SZ_B / SZ_H / SZ_W)
//   addr_lo     : byte offset inside the 32-bit word
//   is_unsigned : zero-extend loads when set, sign-extend otherwise
//   old_word    : word read back from the peripheral
//   new_data    : right-aligned store data
//   load_data   : extracted and extended load result
//   store_word  : old_word with the store bytes merged in
module mmio_lane
  import mmio_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    shamt   = {addr_lo, 3'b000};
    shifted = old_word >> shamt;
    case (size)
      SZ_B: begin
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        mask      = 32'h0000_00FF << shamt;
      end
      SZ_H: begin
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        mask      = 32'h0000_FFFF << shamt;
      end
      default: begin
        load_data = old_word;
        mask      = 32'hFFFF_FFFF;
      end
    endcase
    store_word = (old_word & ~mask) | ((new_data << shamt) & mask);
  end

endmodule

// File: rtl/mmio_initiator.sv
// mmio_initiator: CPU-side initiator for the memory-mapped IO register port.
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     cpu_req/we/addr/size  : load/store request from the memory stage
//     cpu_unsigned          : zero-extend loads
//     cpu_wdata             : right-aligned store data
//     cpu_busy              : high while not IDLE
//     cpu_done/err/rdata    : one-cycle completion with status and load data
//     io_address            : 0 = output register, 1 = input register
//     io_wr_H_rd_L          : 1 = write, 0 = read
//     io_datain             : write data to the peripheral
//     io_dataout            : registered read data from the peripheral
//   Sub-word stores are read-modify-write since the peripheral only takes
//   full-word writes. Every output comes straight from a flop.
module mmio_initiator
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          WIN_BITS  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic        io_address,
  output logic        io_wr_H_rd_L,
  output logic [31:0] io_datain,
  input  logic [31:0] io_dataout
);

  mmio_state_e state;

  logic        req_we;
  logic [1:0]  req_addr_lo;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;

  logic        req_err;
  logic [31:0] lane_load;
  logic [31:0] lane_store;

  // Request check, evaluated only when a request is accepted in IDLE.
  always_comb begin
    req_err = 1'b0;
    if (cpu_addr[31:WIN_BITS] != BASE_ADDR[31:WIN_BITS]) req_err = 1'b1;
    if (cpu_size == 2'd3)                                req_err = 1'b1;
    if (cpu_size == SZ_H && cpu_addr[0])                 req_err = 1'b1;
    if (cpu_size == SZ_W && cpu_addr[1:0] != 2'b00)      req_err = 1'b1;
    if (cpu_we && cpu_addr[2] == OFF_IN[2])              req_err = 1'b1;
  end

  // Request fields are data: latched on acceptance, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req) begin
      req_we       <= cpu_we;
      req_addr_lo  <= cpu_addr[1:0];
      req_size     <= cpu_size;
      req_unsigned <= cpu_unsigned;
      req_wdata    <= cpu_wdata;
    end
  end

  mmio_lane u_lane (
    .size        (req_size),
    .addr_lo     (req_addr_lo),
    .is_unsigned (req_unsigned),
    .old_word    (io_dataout),
    .new_data    (req_wdata),
    .load_data   (lane_load),
    .store_word  (lane_store)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cpu_busy     <= 1'b0;
      cpu_done     <= 1'b0;
      cpu_err      <= 1'b0;
      cpu_rdata    <= '0;
      io_address   <= 1'b0;
      io_wr_H_rd_L <= 1'b0;
      io_datain    <= '0;
    end else begin
      // Pulses and bus controls default low; io_address idles on the
      // output register, which makes the idle read harmless.
      cpu_done     <= 1'b0;
      cpu_err      <= 1'b0;
      io_address   <= 1'b0;
      io_wr_H_rd_L <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cpu_busy  <= 1'b1;
            cpu_rdata <= '0;
            if (req_err) begin
              state    <= RESP;
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
            end else if (!cpu_we || cpu_size != SZ_W) begin
              // Loads and sub-word stores both start with a read.
              state      <= RD;
              io_address <= cpu_addr[2];
            end else begin
              state        <= WR;
              io_wr_H_rd_L <= 1'b1;
              io_datain    <= cpu_wdata;
            end
          end
        end
        RD: state <= RCAP;
        RCAP: begin
          // io_dataout now holds the word addressed during RD.
          if (!req_we) begin
            state     <= RESP;
            cpu_done  <= 1'b1;
            cpu_rdata <= lane_load;
          end else begin
            state        <= WR;
            io_wr_H_rd_L <= 1'b1;
            io_datain    <= lane_store;
          end
        end
        WR: begin
          state    <= RESP;
          cpu_done <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          cpu_busy  <= 1'b0;
          cpu_rdata <= '0;
        end
        default: begin
          state    <= IDLE;
          cpu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_initiator.sv
// tb_mmio_initiator: self-checking bench for mmio_initiator with a
// two-register peripheral model and a byte-level reference model.
module tb_mmio_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_size;
  logic        cpu_unsigned;
  logic [31:0] cpu_wdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [31:0] cpu_rdata;
  logic        io_address;
  logic        io_wr_H_rd_L;
  logic [31:0] io_datain;
  logic [31:0] io_dataout;

  logic [31:0] per_out = 32'h0;
  logic [31:0] in_val  = 32'h0;
  logic [31:0] model_out;

  int n_tests = 0;
  int n_fail  = 0;

  mmio_initiator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_size     (cpu_size),
    .cpu_unsigned (cpu_unsigned),
    .cpu_wdata    (cpu_wdata),
    .cpu_busy     (cpu_busy),
    .cpu_done     (cpu_done),
    .cpu_err      (cpu_err),
    .cpu_rdata    (cpu_rdata),
    .io_address   (io_address),
    .io_wr_H_rd_L (io_wr_H_rd_L),
    .io_datain    (io_datain),
    .io_dataout   (io_dataout)
  );

  always #5 clk = ~clk;

  // Peripheral: registered read of the addressed register, write at the edge.
  always @(posedge clk) begin
    io_dataout <= io_address ? in_val : per_out;
    if (io_wr_H_rd_L) per_out <= io_datain;
  end

  // ---------------- reference model ----------------
  function automatic bit ref_err(input logic we, input logic [31:0] a, input int sz);
    if ((a >> 3) != (32'h8000_0000 >> 3)) return 1'b1;
    if (sz == 3) return 1'b1;
    if (sz == 1 && (a % 2) != 0) return 1'b1;
    if (sz == 2 && (a % 4) != 0) return 1'b1;
    if (we && (a & 32'd4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                           input int sz, input bit uns);
    longint v;
    int bits;
    bits = 8 << sz;
    v = longint'(w >> (8 * (a % 4))) & ((longint'(1) << bits) - 1);
    if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                            input int sz, input logic [31:0] wd);
    logic [31:0] r;
    int off;
    r = old;
    off = int'(a % 4);
    for (int b = 0; b < (1 << sz); b++) r[8*(off+b) +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic int ref_lat(input bit err, input logic we, input int sz);
    if (err) return 1;
    if (!we) return 3;
    if (sz == 2) return 2;
    return 4;
  endfunction

  // ---------------- transaction driver ----------------
  // lat counts negedge samples after the accepting edge until cpu_done.
  task automatic run_txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int wr_cycles, output logic [31:0] wr_data,
                         output bit bus_ok);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_size = sz;
    cpu_unsigned = uns; cpu_wdata = wd;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    lat = 99; wr_cycles = 0; wr_data = 32'h0; rd = 32'hX; err = 1'bX; bus_ok = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!cpu_busy) bus_ok = 1'b0;
      if (io_wr_H_rd_L) begin
        wr_cycles++;
        wr_data = io_datain;
        if (io_address !== 1'b0) bus_ok = 1'b0;
      end
      if (cpu_done) begin
        lat = c; rd = cpu_rdata; err = cpu_err;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({cpu_busy, cpu_done, cpu_err, io_address, io_wr_H_rd_L} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000",
               {cpu_busy, cpu_done, cpu_err, io_address, io_wr_H_rd_L});
    end
    n_tests++;
    if (cpu_rdata !== 32'h0 || io_datain !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: rdata %h datain %h required 0", cpu_rdata, io_datain);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd, wdat; logic err; int lat, wc; bit ok;
    run_txn(1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'hDEADBEEF, rd, err, lat, wc, wdat, ok);
    model_out = 32'hDEADBEEF;
    n_tests++;
    if (lat !== 2 || err !== 1'b0 || wc !== 1 || wdat !== 32'hDEADBEEF || !ok || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL word_store: lat %0d err %b wr %0d data %h ok %0d rd %h required 2 0 1 deadbeef 1 0",
               lat, err, wc, wdat, ok, rd);
    end
    run_txn(1'b0, 32'h8000_0000, 2'd2, 1'b0, 32'h0, rd, err, lat, wc, wdat, ok);
    n_tests++;
    if (lat !== 3 || err !== 1'b0 || wc !== 0 || rd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL word_load: lat %0d err %b wr %0d rd %h required 3 0 0 deadbeef", lat, err, wc, rd);
    end
  endtask

  task automatic test_subword_load;
    logic [31:0] rd, wdat; logic err; int lat, wc; bit ok;
    run_txn(1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'h8012_3456, rd, err, lat, wc, wdat, ok);
    model_out = 32'h8012_3456;
    run_txn(1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'h0, rd, err, lat, wc, wdat, ok);
    n_tests++;
    if (rd !== 32'hFFFF_FF80 || err !== 1'b0 || lat !== 3) begin
      n_fail++;
      $display("FAIL byte_load_signed: rd %h lat %0d required ffffff80 3", rd, lat);
    end
    run_txn(1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0, rd, err, lat, wc, wdat, ok);
    n_tests++;
    if (rd !== 32'h0000_0080 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_load_unsigned: rd %h required 00000080", rd);
    end
    run_txn(1'b0, 32'h8000_0000, 2'd1, 1'b0, 32'h0, rd, err, lat, wc, wdat, ok);
    n_tests++;
    if (rd !== 32'h0000_3456 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL half_load: rd %h required 00003456", rd);
    end
  endtask

  task automatic test_rmw;
    logic [31:0] rd, wdat; logic err; int lat, wc; bit ok;
    run_txn(1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'h1122_3344, rd, err, lat, wc, wdat, ok);
    run_txn(1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_BEEF, rd, err, lat, wc, wdat, ok);
    model_out = 32'hBEEF_3344;
    n_tests++;
    if (lat !== 4 || err !== 1'b0 || wc !== 1 || wdat !== 32'hBEEF_3344 || !ok) begin
      n_fail++;
      $display("FAIL half_store_rmw: lat %0d err %b wr %0d data %h required 4 0 1 beef3344",
               lat, err, wc, wdat);
    end
    @(negedge clk);
    n_tests++;
    if (per_out !== 32'hBEEF_3344) begin
      n_fail++;
      $display("FAIL rmw_reg: got %h required beef3344", per_out);
    end
  endtask

  task automatic test_input_reg;
    logic [31:0] rd, wdat; logic err; int lat, wc; bit ok;
    in_val = 32'h0000_A5A5;
    repeat (3) @(negedge clk);
    run_txn(1'b0, 32'h8000_0004, 2'd2, 1'b0, 32'h0, rd, err, lat, wc, wdat, ok);
    n_tests++;
    if (rd !== 32'h0000_A5A5 || err !== 1'b0 || lat !== 3) begin
      n_fail++;
      $display("FAIL input_reg_load: rd %h err %b lat %0d required 0000a5a5 0 3", rd, err, lat);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd, wdat; logic err; int lat, wc; bit ok;
    logic [31:0] addrs [4] = '{32'h8000_0002, 32'h8000_0004, 32'h9000_0000, 32'h8000_0000};
    logic [1:0]  sizes [4] = '{2'd2, 2'd2, 2'd2, 2'd3};
    logic        wes   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_txn(wes[i], addrs[i], sizes[i], 1'b0, 32'h5555_AAAA, rd, err, lat, wc, wdat, ok);
      @(negedge clk);
      n_tests++;
      if (lat !== 1 || err !== 1'b1 || wc !== 0 || rd !== 32'h0 || per_out !== model_out) begin
        n_fail++;
        $display("FAIL error_case%0d: lat %0d err %b wr %0d rd %h reg %h required 1 1 0 0 %h",
                 i, lat, err, wc, rd, per_out, model_out);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, wdat; logic err; int lat, wc, dc; bit ok;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8000_0001; cpu_size = 2'd0;
    cpu_unsigned = 1'b0; cpu_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(posedge clk);  // now in RCAP
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cpu_busy, cpu_done, cpu_err, io_address, io_wr_H_rd_L} !== 5'b0 ||
        cpu_rdata !== 32'h0 || io_datain !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: ctrl %b rdata %h datain %h required all 0",
               {cpu_busy, cpu_done, cpu_err, io_address, io_wr_H_rd_L}, cpu_rdata, io_datain);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wc = 0; dc = 0;
    repeat (6) begin
      @(negedge clk);
      if (io_wr_H_rd_L) wc++;
      if (cpu_done) dc++;
    end
    n_tests++;
    if (wc !== 0 || dc !== 0 || per_out !== model_out) begin
      n_fail++;
      $display("FAIL reset_mid_abort: writes %0d dones %0d reg %h required 0 0 %h",
               wc, dc, per_out, model_out);
    end
    run_txn(1'b1, 32'h8000_0000, 2'd2, 1'b0, 32'hCAFE_F00D, rd, err, lat, wc, wdat, ok);
    model_out = 32'hCAFE_F00D;
    n_tests++;
    if (lat !== 2 || err !== 1'b0 || wc !== 1 || wdat !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL reset_mid_recover: lat %0d err %b wr %0d data %h required 2 0 1 cafef00d",
               lat, err, wc, wdat);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, wdat, a, wd, exp_rd, exp_wd; logic err, we, uns; int lat, wc, sz; bit ok, e;
    for (int i = 0; i < 60; i++) begin
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz  = $urandom_range(0, 3);
      a   = ($urandom_range(0, 7) == 0) ? $urandom : (32'h8000_0000 | $urandom_range(0, 7));
      wd  = $urandom;
      in_val = $urandom;
      e      = ref_err(we, a, sz);
      exp_rd = (e || we) ? 32'h0 : ref_load(a[2] ? in_val : model_out, a, sz, uns);
      exp_wd = ref_store(model_out, a, sz, wd);
      run_txn(we, a, 2'(sz), uns, wd, rd, err, lat, wc, wdat, ok);
      n_tests++;
      if (err !== e || rd !== exp_rd || lat !== ref_lat(e, we, sz) ||
          wc !== ((we && !e) ? 1 : 0) || (we && !e && wdat !== exp_wd) || !ok) begin
        n_fail++;
        $display("FAIL random%0d we=%b a=%h sz=%0d: err %b rd %h lat %0d wr %0d data %h ok %0d required %b %h %0d %0d %h",
                 i, we, a, sz, err, rd, lat, wc, wdat, ok, e, exp_rd, ref_lat(e, we, sz),
                 (we && !e) ? 1 : 0, exp_wd);
      end
      if (we && !e) model_out = exp_wd;
    end
    @(negedge clk);
    n_tests++;
    if (per_out !== model_out) begin
      n_fail++;
      $display("FAIL random_final_reg: got %h required %h", per_out, model_out);
    end
  endtask

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0;
    cpu_size = 2'd0; cpu_unsigned = 1'b0; cpu_wdata = 32'h0;
    model_out = 32'h0;
    test_reset;
    test_word_store_load;
    test_subword_load;
    test_rmw;
    test_input_reg;
    test_errors;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
